mem_arbiter: RTL and testbench

- Shares the single byte-wide RAM port between the instruction fetch path and the load/store buffer.
- It serialises multi-byte requests into byte cycles and assembles read data into words.
- It arbitrates round-robin between the two requesters.
- It aborts speculative reads on a ROB mispredict flush; committed stores always complete.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and helpers for the RAM port arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

    // Byte count of a load/store; size code 3 behaves like a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin byte-serialising arbiter for the shared RAM port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(IO_BASE_DEF),
    parameter int                IF_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_e            state, state_n;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q, asm_n;
    logic              prio_ls;
    logic              wr_q;

    logic              grant_if, grant_ls, step, finish, abort, io_stall;
    logic              is_rd, last, io_full_hit;
    logic [2:0]        n_bytes;
    logic [1:0]        byte_sel;
    logic [ADDR_W-1:0] addr_n;

    // Write strobe drops while frozen so the held byte is re-issued once rdy returns.
    assign mem_wr = wr_q & rdy;

    // Next-state and per-edge control decisions; nothing advances while rdy is low.
    always_comb begin
        state_n  = state;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        abort    = 1'b0;
        io_stall = 1'b0;

        is_rd       = (state == ST_IF_RD) || (state == ST_LS_RD);
        n_bytes     = (state == ST_IF_RD) ? 3'(IF_BYTES) : size_bytes(size_q);
        last        = (cnt == n_bytes);
        io_full_hit = (base_q >= IO_BASE) && io_buffer_full;
        byte_sel    = 2'(cnt - 3'd1);
        addr_n      = base_q + ADDR_W'(cnt) + (is_rd ? ADDR_W'(1) : ADDR_W'(0));

        asm_n = asm_q;
        if (cnt != 3'd0) begin
            asm_n[{byte_sel, 3'b000} +: 8] = mem_din;
        end

        if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (!flush) begin
                        if (if_req && ls_req) begin
                            grant_ls = prio_ls;
                            grant_if = !prio_ls;
                        end else begin
                            grant_if = if_req;
                            grant_ls = ls_req;
                        end
                    end
                    if (grant_if) begin
                        state_n = ST_IF_RD;
                    end else if (grant_ls) begin
                        state_n = ls_wr ? ST_LS_WR : ST_LS_RD;
                    end
                end
                ST_IF_RD, ST_LS_RD: begin
                    if (flush) begin
                        abort   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (last) begin
                        finish  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
                default: begin
                    if (last) begin
                        finish  = 1'b1;
                        state_n = ST_IDLE;
                    end else if (io_full_hit) begin
                        io_stall = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Byte counter, RAM port drive, word assembly and done pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 3'd0;
            base_q   <= '0;
            size_q   <= SIZE_B;
            wdata_q  <= '0;
            asm_q    <= '0;
            prio_ls  <= 1'b1;
            wr_q     <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
            if_done  <= 1'b0;
            if_data  <= '0;
            ls_done  <= 1'b0;
            ls_rdata <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            if (grant_if || grant_ls) begin
                base_q  <= grant_if ? if_addr : ls_addr;
                mem_a   <= grant_if ? if_addr : ls_addr;
                size_q  <= (grant_ls && ls_size != 2'd3) ? ls_size : SIZE_W;
                wdata_q <= ls_wdata;
                cnt     <= 3'd0;
                asm_q   <= '0;
                wr_q    <= 1'b0;
                // Contended grant: the loser wins the next tie.
                if (if_req && ls_req) begin
                    prio_ls <= grant_if;
                end
            end
            if (step) begin
                cnt   <= cnt + 3'd1;
                mem_a <= addr_n;
                if (is_rd) begin
                    asm_q <= asm_n;
                end else begin
                    mem_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
                    wr_q     <= 1'b1;
                end
            end
            if (finish) begin
                cnt   <= 3'd0;
                mem_a <= '0;
                wr_q  <= 1'b0;
                case (state)
                    ST_IF_RD: begin
                        if_done <= 1'b1;
                        if_data <= asm_n;
                    end
                    ST_LS_RD: begin
                        ls_done  <= 1'b1;
                        ls_rdata <= asm_n;
                    end
                    default: ls_done <= 1'b1;
                endcase
            end
            if (abort) begin
                cnt   <= 3'd0;
                mem_a <= '0;
                wr_q  <= 1'b0;
            end
            if (io_stall) begin
                wr_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        if_req, if_done, ls_req, ls_wr, ls_done;
    logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata, mem_a;
    logic [1:0]  ls_size;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_wr, io_buffer_full;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // RAM: 4 KB window, registered read frozen together with the rest of the system by rdy.
    logic [7:0]  ram [0:4095];
    bit   [4095:0] ram_vld;
    logic [39:0] wlog [$];
    logic [7:0]  model_mem [0:4095];

    function automatic logic [7:0] init_byte(input logic [11:0] a);
        case (a)
            12'h100: return 8'h13;  12'h101: return 8'h05;
            12'h102: return 8'h00;  12'h103: return 8'h00;
            12'h104: return 8'hAA;  12'h105: return 8'hBB;
            12'h106: return 8'h34;  12'h107: return 8'h12;
            12'h108: return 8'h78;  12'h109: return 8'h56;
            12'h10A: return 8'h34;  12'h10B: return 8'h12;
            12'hFFE: return 8'hEE;  12'hFFF: return 8'hFF;
            12'h000: return 8'h00;  12'h001: return 8'h11;
            default: return 8'(a) * 8'd7 + 8'd3;
        endcase
    endfunction

    function automatic logic [7:0] mem_rd(input logic [11:0] a);
        return ram_vld[a] ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] rd_ram(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mem_rd(12'(a + 32'(k)));
        return r;
    endfunction

    always @(posedge clk) begin
        if (rdy) mem_din <= mem_rd(mem_a[11:0]);
        if (mem_wr) begin
            ram[mem_a[11:0]]     <= mem_dout;
            ram_vld[mem_a[11:0]] <= 1'b1;
            wlog.push_back({mem_a, mem_dout});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request from the IDLE state; flush is high before edge flush_cyc (0 = never).
    task automatic do_xfer(input bit is_if, input bit wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input int flush_cyc,
                           output int lat, output logic [31:0] data, output int nwr,
                           output logic [31:0] a_after);
        int w0;
        w0 = wlog.size();
        lat = -1; data = '0; a_after = '1;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
        end
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (flush_cyc != 0 && c == flush_cyc + 1) a_after = mem_a;
            if (c > 1 && (is_if ? if_done : ls_done)) begin
                lat = c - 1;
                data = is_if ? if_data : ls_rdata;
                break;
            end
            flush = (flush_cyc == c);
            if (flush && !(wr && !is_if)) begin
                if_req = 1'b0; ls_req = 1'b0;
            end
            if (c < 14) @(posedge clk);
        end
        flush = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        nwr = wlog.size() - w0;
    endtask

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp;
        int          nwr;
    } vec_t;

    vec_t vt [11];

    initial begin
        int          lat, nwr, nd, w0, wr_seen, n, kind;
        logic [31:0] data, af, first_if, addr, wdata, exp;
        logic [3:0]  ord;
        logic [1:0]  size;
        bit          got;

        vt[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         5, 32'h0000_0513, 0};
        vt[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0104, 32'h0,         2, 32'h0000_00AA, 0};
        vt[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0106, 32'h0,         3, 32'h0000_1234, 0};
        vt[3]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0108, 32'h0,         5, 32'h1234_5678, 0};
        vt[4]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0108, 32'h0,         5, 32'h1234_5678, 0};
        vt[5]  = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0,         5, 32'h1100_FFEE, 0};
        vt[6]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0200, 32'h0000_BEEF, 3, 32'h0000_BEEF, 2};
        vt[7]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0210, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 4};
        vt[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0220, 32'h1234_56A5, 2, 32'h0000_00A5, 1};
        vt[9]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0210, 32'h0,         5, 32'hCAFE_F00D, 0};
        vt[10] = '{1'b0, 1'b0, 2'd1, 32'h0000_0104, 32'h0,         3, 32'h0000_BBAA, 0};

        for (int i = 0; i < 4096; i++) model_mem[i] = init_byte(12'(i));

        rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0;
        ls_addr = '0; ls_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {if_done, ls_done, mem_wr, mem_dout, mem_a}, 64'h0);
        check("reset_data", {if_data, ls_rdata}, 64'h0);
        rst = 1'b1;

        // Round robin: both held, loads/stores first after reset.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h104;
        ord = '0; nd = 0; first_if = '0;
        for (int c = 0; c < 80 && nd < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (ls_done) begin ord = {ord[2:0], 1'b0}; nd++; end
            if (if_done) begin ord = {ord[2:0], 1'b1}; nd++; if (nd == 2) first_if = if_data; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("rr_count", 64'(nd), 64'd4);
        check("rr_order", 64'(ord), 64'h5);
        check("rr_if_data", 64'(first_if), 64'h513);

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            w0 = wlog.size();
            do_xfer(vt[i].is_if, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, 0, lat, data, nwr, af);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("vec%0d_writes", i), 64'(nwr), 64'(vt[i].nwr));
            if (vt[i].wr) begin
                check($sformatf("vec%0d_ram", i), 64'(rd_ram(vt[i].addr, vt[i].nwr)), 64'(vt[i].exp));
                check($sformatf("vec%0d_first_write", i),
                      64'((wlog.size() > w0) ? wlog[w0] : 40'h0), 64'({vt[i].addr, vt[i].wdata[7:0]}));
            end else begin
                check($sformatf("vec%0d_data", i), 64'(data), 64'(vt[i].exp));
            end
        end

        // IO stall: byte store to IO_BASE while the UART buffer is full for 4 cycles.
        @(negedge clk);
        w0 = wlog.size();
        io_buffer_full = 1'b1; ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0;
        ls_addr = 32'h0003_0000; ls_wdata = 32'h5A;
        @(posedge clk);
        wr_seen = 0;
        repeat (4) begin @(posedge clk); @(negedge clk); wr_seen += int'(mem_wr); end
        check("io_no_write_while_full", 64'(wr_seen), 64'd0);
        io_buffer_full = 1'b0;
        @(posedge clk); @(negedge clk);
        check("io_write_after_clear", {23'h0, mem_wr, mem_a, mem_dout}, {23'h0, 1'b1, 32'h0003_0000, 8'h5A});
        @(posedge clk); @(negedge clk);
        check("io_done", {62'h0, ls_done, mem_wr}, 64'h2);
        ls_req = 1'b0;
        check("io_write_count", 64'(wlog.size() - w0), 64'd1);

        // Flushes.
        do_xfer(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 2, lat, data, nwr, af);
        check("flush_fetch_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        check("flush_fetch_mem_a", 64'(af), 64'h0);
        do_xfer(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 5, lat, data, nwr, af);
        check("flush_at_done_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        do_xfer(1'b0, 1'b1, 2'd2, 32'h240, 32'h1122_3344, 2, lat, data, nwr, af);
        check("flush_store_latency", 64'(lat), 64'd5);
        check("flush_store_writes", 64'(nwr), 64'd4);
        check("flush_store_ram", 64'(rd_ram(32'h240, 4)), 64'h1122_3344);

        // Reset in the middle of a word load.
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h108;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_ctrl", {if_done, ls_done, mem_wr, mem_dout, mem_a}, 64'h0);
        check("midreset_data", {if_data, ls_rdata}, 64'h0);
        ls_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        nd = 0;
        repeat (6) begin @(posedge clk); @(negedge clk); nd += int'(if_done | ls_done); end
        check("midreset_no_done", 64'(nd), 64'd0);
        do_xfer(1'b0, 1'b0, 2'd2, 32'h108, 32'h0, 0, lat, data, nwr, af);
        check("midreset_reload_lat", 64'(lat), 64'd5);
        check("midreset_reload_data", 64'(data), 64'h1234_5678);

        // Random traffic with random rdy freezes against a byte-array memory model.
        for (int t = 0; t < 40; t++) begin
            kind  = int'($urandom_range(0, 2));
            addr  = 32'h800 + 32'($urandom_range(0, 32'h7F0));
            size  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            n     = (kind == 0 || size >= 2'd2) ? 4 : (size == 2'd1 ? 2 : 1);
            exp   = '0;
            for (int k = 0; k < n; k++) begin
                if (kind == 2) exp[8*k +: 8] = wdata[8*k +: 8];
                else           exp[8*k +: 8] = model_mem[12'(addr + 32'(k))];
            end
            w0 = wlog.size();
            if (kind == 0) begin
                if_req = 1'b1; if_addr = addr;
            end else begin
                ls_req = 1'b1; ls_wr = (kind == 2); ls_size = size; ls_addr = addr; ls_wdata = wdata;
            end
            got = 1'b0; data = '0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(posedge clk); @(negedge clk);
                if (kind == 0 ? if_done : ls_done) begin
                    got = 1'b1;
                    data = (kind == 0) ? if_data : ls_rdata;
                end else begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
            end
            rdy = 1'b1; if_req = 1'b0; ls_req = 1'b0;
            check($sformatf("rand%0d_done", t), 64'(got), 64'd1);
            if (kind == 2) begin
                for (int k = 0; k < n; k++) model_mem[12'(addr + 32'(k))] = wdata[8*k +: 8];
                check($sformatf("rand%0d_ram", t), 64'(rd_ram(addr, n)), 64'(exp));
                check($sformatf("rand%0d_writes", t), 64'(wlog.size() - w0), 64'(n));
            end else begin
                check($sformatf("rand%0d_data", t), 64'(data), 64'(exp));
                check($sformatf("rand%0d_writes", t), 64'(wlog.size() - w0), 64'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
